// File: rtl/read_control_if.sv
// rtl/read_control_if.sv - bank read bus and package output stream of read_control
//
// Purpose: bundles the dual-bank RAM read port and the downstream word stream
// so read_control and its environment share one connection.
// Signals:
//   even_rd_addr / odd_rd_addr  14  bank read addresses (controller -> RAM)
//   rden                         1  read strobe to both banks (controller -> RAM)
//   even_q / odd_q              16  bank read data, one cycle after rden (RAM -> controller)
//   out_data                    16  package word (controller -> downstream)
//   out_valid / out_ready        1  downstream handshake, transfer when both high
//   out_sop / out_eop            1  first / last word of a package, qualified by out_valid
// Modports: master = read_control side, slave = RAM + downstream side.

interface read_control_if;
  logic [13:0] even_rd_addr;
  logic [13:0] odd_rd_addr;
  logic        rden;
  logic [15:0] even_q;
  logic [15:0] odd_q;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;

  modport master (
    output even_rd_addr, odd_rd_addr, rden,
    input  even_q, odd_q,
    output out_data, out_valid, out_sop, out_eop,
    input  out_ready
  );

  modport slave (
    input  even_rd_addr, odd_rd_addr, rden,
    output even_q, odd_q,
    input  out_data, out_valid, out_sop, out_eop,
    output out_ready
  );
endinterface

// File: rtl/read_control.sv
// rtl/read_control.sv - reads stored packages from even/odd RAM banks and streams them out
//
// Purpose: counts packages announced by the writer (pkg_done), reads each
// package word by word from the even bank (even k) and odd bank (odd k) and
// delivers the words downstream through a 2-entry output buffer with
// valid/ready flow control, 1 word/cycle when downstream never stalls.
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   pkg_done   one-cycle pulse, one more full package is stored
//   pend_cnt   packages stored but not yet fully issued for read
//   overflow   sticky, a pkg_done arrived while pend_cnt was already PEND_MAX
//   bus        read_control_if.master: bank read port and output stream

module read_control #(
  parameter int PACKAGE_LENGTH = 1036,
  parameter int PEND_MAX       = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pkg_done,
  output logic [3:0]    pend_cnt,
  output logic          overflow,
  read_control_if.master bus
);

  localparam logic [11:0] K_LAST   = 12'(PACKAGE_LENGTH - 1);
  localparam logic [3:0]  PEND_TOP = 4'(PEND_MAX);

  typedef enum logic {IDLE, READ} state_t;

  state_t      state;
  logic [11:0] k;
  logic [13:0] even_addr;
  logic [13:0] odd_addr;

  // Read issued last cycle; its data is on even_q/odd_q this cycle.
  logic        cap_valid;
  logic        cap_odd;
  logic        cap_sop;
  logic        cap_eop;

  // Output buffer: head drives the outputs, skid catches a word while head stalls.
  logic [15:0] head_data;
  logic        head_valid;
  logic        head_sop;
  logic        head_eop;
  logic [15:0] skid_data;
  logic        skid_valid;
  logic        skid_sop;
  logic        skid_eop;

  logic        pop;
  logic [1:0]  held;
  logic        issue;
  logic        last_issue;
  logic        pend_inc;
  logic        pend_dec;
  logic [3:0]  pend_next;
  logic [15:0] cap_data;

  // rden is decided in the same cycle as the pop so the credit loop is one
  // read deep: buffered words left after the pop plus the word returning now
  // must leave room for the word requested now.
  always_comb begin
    pop        = head_valid && bus.out_ready;
    held       = {1'b0, head_valid} + {1'b0, skid_valid} - {1'b0, pop};
    issue      = !rst && (state == READ) && ((held + {1'b0, cap_valid}) < 2'd2);
    last_issue = issue && (k == K_LAST);
    pend_dec   = last_issue;
    // At the ceiling a pkg_done is only taken if a slot frees this same cycle.
    pend_inc   = pkg_done && ((pend_cnt != PEND_TOP) || pend_dec);
    pend_next  = pend_cnt + {3'b000, pend_inc} - {3'b000, pend_dec};
    cap_data   = cap_odd ? bus.odd_q : bus.even_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      k          <= 12'd0;
      even_addr  <= 14'd0;
      odd_addr   <= 14'd0;
      cap_valid  <= 1'b0;
      cap_odd    <= 1'b0;
      cap_sop    <= 1'b0;
      cap_eop    <= 1'b0;
      head_data  <= 16'd0;
      head_valid <= 1'b0;
      head_sop   <= 1'b0;
      head_eop   <= 1'b0;
      skid_data  <= 16'd0;
      skid_valid <= 1'b0;
      skid_sop   <= 1'b0;
      skid_eop   <= 1'b0;
      pend_cnt   <= 4'd0;
      overflow   <= 1'b0;
    end else begin
      pend_cnt <= pend_next;
      if (pkg_done && (pend_cnt == PEND_TOP) && !pend_dec) begin
        overflow <= 1'b1;
      end

      // Entering READ on the edge that makes pend_cnt nonzero saves a cycle
      // of latency; leaving only when no further package waits keeps
      // back-to-back packages without a bubble.
      case (state)
        IDLE: if (pend_next != 4'd0) state <= READ;
        READ: if (last_issue && (pend_next == 4'd0)) state <= IDLE;
      endcase

      if (issue) begin
        k <= last_issue ? 12'd0 : k + 12'd1;
        if (k[0]) begin
          odd_addr <= odd_addr + 14'd1;
        end else begin
          even_addr <= even_addr + 14'd1;
        end
      end

      cap_valid <= issue;
      cap_odd   <= k[0];
      cap_sop   <= (k == 12'd0);
      cap_eop   <= (k == K_LAST);

      if (!head_valid || pop) begin
        if (skid_valid) begin
          head_data  <= skid_data;
          head_sop   <= skid_sop;
          head_eop   <= skid_eop;
          head_valid <= 1'b1;
          skid_valid <= cap_valid;
          if (cap_valid) begin
            skid_data <= cap_data;
            skid_sop  <= cap_sop;
            skid_eop  <= cap_eop;
          end
        end else begin
          head_valid <= cap_valid;
          if (cap_valid) begin
            head_data <= cap_data;
            head_sop  <= cap_sop;
            head_eop  <= cap_eop;
          end
        end
      end else if (cap_valid) begin
        skid_valid <= 1'b1;
        skid_data  <= cap_data;
        skid_sop   <= cap_sop;
        skid_eop   <= cap_eop;
      end
    end
  end

  assign bus.even_rd_addr = even_addr;
  assign bus.odd_rd_addr  = odd_addr;
  assign bus.rden         = issue;
  assign bus.out_data     = head_data;
  assign bus.out_valid    = head_valid;
  assign bus.out_sop      = head_sop;
  assign bus.out_eop      = head_eop;

endmodule

// File: tb/tb_read_control.sv
// tb/tb_read_control.sv - self-checking bench for read_control

module tb_read_control;

  localparam int PL = 1036;
  localparam int PM = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       pkg_done;
  logic [3:0] pend_cnt;
  logic       overflow;

  read_control_if bus ();

  read_control #(.PACKAGE_LENGTH(PL), .PEND_MAX(PM)) dut (
    .clk      (clk),
    .rst      (rst),
    .pkg_done (pkg_done),
    .pend_cnt (pend_cnt),
    .overflow (overflow),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] even_mem [16384];
  logic [15:0] odd_mem  [16384];

  always @(posedge clk) begin
    if (bus.rden) begin
      bus.even_q <= even_mem[bus.even_rd_addr];
      bus.odd_q  <= odd_mem[bus.odd_rd_addr];
    end
  end

  int passed = 0;
  int failed = 0;
  int total  = 0;

  int cyc = 0;
  int words, exp_p, exp_k, pkgs_expected, pkgs_done;
  int first_cyc, last_cyc, wrap_seen;
  logic held_prev;
  logic [13:0] prev_even;

  task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  // Word k of the p-th package since reset: bank address advances by half a
  // package per package, data was preloaded as 2*addr (even) / 2*addr+1 (odd).
  function automatic logic [15:0] exp_word(input int p, input int k);
    int a;
    a = (p * (PL / 2) + k / 2) % 16384;
    return (k % 2 == 1) ? 16'(2 * a + 1) : 16'(2 * a);
  endfunction

  task automatic clear_model();
    words = 0; exp_p = 0; exp_k = 0; pkgs_expected = 0; pkgs_done = 0;
    first_cyc = -1; last_cyc = -1; held_prev = 1'b0; prev_even = 14'd0;
  endtask

  task automatic observe(input logic r);
    if (held_prev) check("valid_hold", words, 32'(bus.out_valid), 32'd1);
    if (prev_even == 14'h3FFF && bus.even_rd_addr != 14'h3FFF) begin
      check("addr_wrap", wrap_seen, 32'(bus.even_rd_addr), 32'd0);
      wrap_seen++;
    end
    prev_even = bus.even_rd_addr;
    if (bus.out_valid === 1'b1) begin
      check("has_pkg", words, 32'(exp_p < pkgs_expected), 32'd1);
      check("data", words, 32'(bus.out_data), 32'(exp_word(exp_p, exp_k)));
      check("sop", words, 32'(bus.out_sop), 32'(exp_k == 0));
      check("eop", words, 32'(bus.out_eop), 32'(exp_k == PL - 1));
      if (bus.out_ready && !r) begin
        if (exp_k == 0 && first_cyc < 0) first_cyc = cyc;
        if (exp_k == PL - 1) begin
          last_cyc = cyc;
          exp_k = 0;
          exp_p++;
          pkgs_done++;
        end else begin
          exp_k++;
        end
        words++;
      end
    end
    held_prev = (bus.out_valid === 1'b1) && !bus.out_ready && !r;
  endtask

  // Inputs change on the falling edge and are sampled by the next rising edge;
  // registered outputs are observed at the same falling edge.
  task automatic step(input logic rdy, input logic pd, input logic r);
    @(negedge clk);
    bus.out_ready = rdy;
    pkg_done = pd;
    rst = r;
    cyc++;
    if (pd && !r && (pkgs_expected - pkgs_done) < PM) pkgs_expected++;
    observe(r);
  endtask

  task automatic run_until(input int target, input int pct, input int budget);
    int n;
    n = 0;
    while (words < target && n < budget) begin
      step(($urandom_range(99, 0) < pct), 1'b0, 1'b0);
      n++;
    end
    check("run_timeout", target, 32'(words), 32'(target));
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b1);
    clear_model();
    step(1'b0, 1'b0, 1'b0);
    check("rst_valid", 0, 32'(bus.out_valid), 32'd0);
    check("rst_sop", 0, 32'(bus.out_sop), 32'd0);
    check("rst_eop", 0, 32'(bus.out_eop), 32'd0);
    check("rst_data", 0, 32'(bus.out_data), 32'd0);
    check("rst_rden", 0, 32'(bus.rden), 32'd0);
    check("rst_even_addr", 0, 32'(bus.even_rd_addr), 32'd0);
    check("rst_odd_addr", 0, 32'(bus.odd_rd_addr), 32'd0);
    check("rst_pend", 0, 32'(pend_cnt), 32'd0);
    check("rst_overflow", 0, 32'(overflow), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    pkg_done = 1'b0;
    bus.out_ready = 1'b0;
    wrap_seen = 0;
    clear_model();
    for (int i = 0; i < 16384; i++) begin
      even_mem[i] = 16'(2 * i);
      odd_mem[i]  = 16'(2 * i + 1);
    end

    // Single package at full rate, latency and gap-free delivery.
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("lat_pend", 1, 32'(pend_cnt), 32'd1);
    check("lat_e1", 1, 32'(bus.out_valid), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    check("lat_e2", 2, 32'(bus.out_valid), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    check("lat_e3", 3, 32'(bus.out_valid), 32'd1);
    run_until(PL, 100, PL + 20);
    check("pkg1_span", 0, 32'(last_cyc - first_cyc), 32'(PL - 1));
    step(1'b1, 1'b0, 1'b0);
    check("pkg1_pend_end", 0, 32'(pend_cnt), 32'd0);
    check("pkg1_idle", 0, 32'(bus.out_valid), 32'd0);

    // Three packages announced close together stream without a gap.
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("pend_peak", 3, 32'(pend_cnt), 32'd3);
    run_until(3 * PL, 100, 3 * PL + 20);
    check("pkg3_span", 0, 32'(last_cyc - first_cyc), 32'(3 * PL - 1));
    step(1'b1, 1'b0, 1'b0);
    check("pkg3_pend_end", 0, 32'(pend_cnt), 32'd0);

    // Random backpressure must not lose, duplicate or reorder words.
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    run_until(PL, 50, 8 * PL);
    check("rand_pkgs", 0, 32'(pkgs_done), 32'd1);

    // Push the even address through its wrap point.
    do_reset();
    wrap_seen = 0;
    for (int p = 0; p < 32; p++) begin
      step(1'b1, 1'b1, 1'b0);
      run_until((p + 1) * PL, 100, PL + 20);
    end
    check("wrap_seen", 0, 32'(wrap_seen), 32'd1);

    // Saturation and sticky overflow with downstream blocked.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      if (i == 14) begin
        check("sat_pend15", i, 32'(pend_cnt), 32'd15);
        check("sat_no_ovf", i, 32'(overflow), 32'd0);
      end
    end
    check("ovf_pend", 0, 32'(pend_cnt), 32'd15);
    check("ovf_set", 0, 32'(overflow), 32'd1);
    do_reset();

    // Reset mid-package with a coincident pkg_done, then a clean restart.
    step(1'b1, 1'b1, 1'b0);
    run_until(500, 100, 600);
    step(1'b0, 1'b1, 1'b1);
    clear_model();
    step(1'b1, 1'b0, 1'b0);
    check("abort_valid", 0, 32'(bus.out_valid), 32'd0);
    check("abort_even_addr", 0, 32'(bus.even_rd_addr), 32'd0);
    check("abort_odd_addr", 0, 32'(bus.odd_rd_addr), 32'd0);
    check("abort_pend", 0, 32'(pend_cnt), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("abort_quiet", 0, 32'(bus.out_valid), 32'd0);
    check("abort_pend_q", 0, 32'(pend_cnt), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    run_until(PL, 100, PL + 20);
    check("restart_pkgs", 0, 32'(pkgs_done), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/read_control.md
READ_CONTROL -- requirements
Module: read_control

Interface
REQ-001 SHALL have parameter PACKAGE_LENGTH, default 1036, words per package (even, 4..4094).
REQ-002 SHALL have parameter PEND_MAX, default 15, max packages queued (1..15).
REQ-003 clk  in  1  system clock; the only clock, all logic on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 pkg_done  in  1  one-cycle pulse: writer has finished storing one full package.
REQ-006 even_q  in  16  even-bank RAM read data, valid 1 cycle after address/rden.
REQ-007 odd_q  in  16  odd-bank RAM read data, valid 1 cycle after address/rden.
REQ-008 even_rd_addr  out  14  even-bank read address.
REQ-009 odd_rd_addr  out  14  odd-bank read address.
REQ-010 rden  out  1  read strobe to both banks.
REQ-011 out_data  out  16  package word to downstream.
REQ-012 out_valid / out_ready  out / in  1 / 1  downstream handshake; transfer when both high.
REQ-013 out_sop / out_eop  out  1 / 1  qualify first / last word of a package, meaningful only with out_valid.
REQ-014 pend_cnt  out  4  packages stored but not yet fully issued for read.
REQ-015 overflow  out  1  sticky: pkg_done received with pend_cnt == PEND_MAX.

Function
REQ-016 Word k of a package (k = 0..PACKAGE_LENGTH-1) SHALL come from the even bank for even k and the odd bank for odd k, matching the writer's even/odd split.
REQ-017 Bank read addresses SHALL each start at 0 after reset and increment by 1 after every read issued to that bank, wrapping 14'h3FFF -> 0.
REQ-018 pend_cnt SHALL increment on pkg_done, decrement on the cycle the last word (k = PACKAGE_LENGTH-1) is issued, stay unchanged on coincidence, saturate at PEND_MAX.
REQ-019 pkg_done at PEND_MAX SHALL set overflow and leave pend_cnt unchanged; only rst clears overflow.
REQ-020 FSM states: IDLE, READ. IDLE -> READ when pend_cnt > 0; READ -> IDLE after issuing word PACKAGE_LENGTH-1 if pend_cnt is then 0, else stay in READ with k reset to 0 (back-to-back, no bubble).
REQ-021 A 2-entry output buffer SHALL hold returned words; in READ a read SHALL be issued (rden=1) only when buffered + in-flight words < 2 after this cycle's pop.
REQ-022 Returned data SHALL be selected by the registered parity of the issued k, with sop (k=0) and eop (k=PACKAGE_LENGTH-1) carried alongside.
REQ-023 Latency: first word on out_valid 2 cycles after pkg_done with empty pipeline and out_ready high.
REQ-024 With out_ready held high, throughput SHALL be 1 word/cycle including across package boundaries.
REQ-025 out_valid with out_data/sop/eop SHALL stay stable until accepted; out_ready low SHALL NOT lose or duplicate words.
REQ-026 k counter SHALL be 12 bits, wrap to 0 after PACKAGE_LENGTH-1.

Reset
REQ-027 rst SHALL set: state IDLE, k=0, both addresses 0, rden=0, buffer empty, out_valid=0, out_sop=0, out_eop=0, out_data=0, pend_cnt=0, overflow=0.
REQ-028 rst mid-package SHALL abort immediately: in-flight RAM data discarded, no partial word emitted the next cycle.
REQ-029 pkg_done coincident with rst SHALL be ignored.

Verification
REQ-030 Preload even[i]=2i, odd[i]=2i+1; one pkg_done, out_ready=1 -> 1036 words 0..1035 on consecutive cycles, sop on 0, eop on 1035, pend_cnt 1->0.
REQ-031 Three pkg_done pulses 1 cycle apart -> pend_cnt peaks 3; 3108 words, no gap, second package sop at even_rd_addr=518.
REQ-032 Random out_ready (50%) -> output sequence identical to REQ-030; out_valid never drops without acceptance.
REQ-033 Addresses preset near wrap via 31 packages -> even_rd_addr goes 3FFF -> 0000 without a skipped word.
REQ-034 16 pkg_done with out_ready=0 -> pend_cnt=15, overflow=1; rst -> both 0.
REQ-035 rst asserted at word 500 -> next cycle out_valid=0, addresses 0; new pkg_done restarts at word 0.
